hazard_stall_ctrl: RTL

//  Pipeline interlock controller for the 5-stage MIPS core; companion to the EX-stage forwarding unit.

---
 rtl/hazard_stall_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock controller: load-use bubble, MDU occupancy stall and
// taken-branch flush, plus a saturating count of stalled cycles.
module hazard_stall_ctrl #(
    parameter int unsigned MDU_LAT = 32,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned PERF_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_EX,
    input  logic [4:0]        RegWrAddr_EX,
    input  logic [4:0]        RsAddr_ID,
    input  logic [4:0]        RtAddr_ID,
    input  logic              UseRt_ID,
    input  logic              MduStart_EX,
    input  logic              MduUse_ID,
    input  logic              BranchTaken_EX,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Flush,
    output logic              MduBusy,
    output logic [PERF_W-1:0] StallCnt
);

    if ((MDU_LAT < 1) || (longint'(MDU_LAT) > (longint'(1) << CNT_W))) begin : gBadLat
        $error("hazard_stall_ctrl: MDU_LAT-1 must fit in CNT_W bits and MDU_LAT >= 1");
    end

    typedef enum logic {IDLE, BUSY} mduState_t;

    mduState_t        state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             loadUse, mduHaz, stall;

    // Hazard detection; a taken branch squashes ID so it never interlocks.
    always_comb begin
        loadUse = MemRead_EX && (RegWrAddr_EX != 5'd0) &&
                  ((RegWrAddr_EX == RsAddr_ID) || (UseRt_ID && (RegWrAddr_EX == RtAddr_ID)));
        mduHaz  = MduUse_ID && ((state == BUSY) || MduStart_EX);
        stall   = (loadUse || mduHaz) && !BranchTaken_EX;
    end

    // Pipeline control; reset forces a frozen, flushed front end.
    always_comb begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
        if (!reset) begin
            PCWrite     = !stall;
            IF_ID_Write = !stall;
            IF_ID_Flush = BranchTaken_EX;
            ID_EX_Flush = stall || BranchTaken_EX;
        end
    end

    // MDU occupancy FSM: busy for exactly MDU_LAT cycles after a start.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        unique case (state)
            IDLE: begin
                if (MduStart_EX && !BranchTaken_EX) begin
                    stateNext = BUSY;
                    cntNext   = CNT_W'(MDU_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    assign MduBusy = (state == BUSY);

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= '0;
        end else if (stall && (StallCnt != {PERF_W{1'b1}})) begin
            StallCnt <= StallCnt + PERF_W'(1);
        end
    end

endmodule
